// File: rtl/display_scan_ctrl.sv
// 3-digit display sequencer: binary-to-BCD conversion (one shift per clock) feeding
// a time-multiplexed BCD nibble bus with active-low digit commons and leading-zero blanking.
module display_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       btn_reset,
    input  logic [7:0] val_in,
    input  logic       val_valid,
    output logic       val_ready,
    output logic       busy,
    output logic       conv_done,
    output logic [2:0] dig,
    output logic [3:0] bcd_out
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [19:0] shift_reg;
    logic [19:0] shift_adj;
    logic [19:0] shift_nxt;
    logic [2:0]  bit_cnt;
    logic [3:0]  hun, ten, uni;
    logic        accept;

    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       digit_idx;
    logic             refresh_wrap;
    logic [2:0]       dig_nxt;
    logic [3:0]       bcd_nxt;
    logic             blank_hun, blank_ten;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    assign accept    = val_valid && val_ready;
    assign val_ready = (state == IDLE);
    assign busy      = (state == SHIFT) || (state == COMMIT);

    assign shift_adj = {add3(shift_reg[19:16]), add3(shift_reg[15:12]),
                        add3(shift_reg[11:8]), shift_reg[7:0]};
    assign shift_nxt = shift_adj << 1;

    always_ff @(posedge clk or posedge btn_reset) begin
        if (btn_reset) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (bit_cnt == 3'd7) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge btn_reset) begin
        if (btn_reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            hun       <= '0;
            ten       <= '0;
            uni       <= '0;
            conv_done <= 1'b0;
        end else begin
            conv_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg <= {12'b0, val_in};
                        bit_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_nxt;
                    bit_cnt   <= bit_cnt + 3'd1;
                end
                COMMIT: begin
                    hun       <= shift_reg[19:16];
                    ten       <= shift_reg[15:12];
                    uni       <= shift_reg[11:8];
                    conv_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Scan runs freely; a commit only changes the nibble shown, never the slot timing.
    assign refresh_wrap = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));

    always_ff @(posedge clk or posedge btn_reset) begin
        if (btn_reset) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else begin
            if (refresh_wrap) begin
                refresh_cnt <= '0;
                digit_idx   <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
        end
    end

    assign blank_hun = BLANK_LZ && (hun == 4'd0);
    assign blank_ten = BLANK_LZ && (hun == 4'd0) && (ten == 4'd0);

    always_comb begin
        dig_nxt = 3'b111;
        bcd_nxt = 4'hF;
        case (digit_idx)
            2'd0: begin
                dig_nxt = 3'b110;
                bcd_nxt = uni;
            end
            2'd1: if (!blank_ten) begin
                dig_nxt = 3'b101;
                bcd_nxt = ten;
            end
            2'd2: if (!blank_hun) begin
                dig_nxt = 3'b011;
                bcd_nxt = hun;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge btn_reset) begin
        if (btn_reset) begin
            dig     <= 3'b111;
            bcd_out <= 4'hF;
        end else begin
            dig     <= dig_nxt;
            bcd_out <= bcd_nxt;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: handshake, conversion latency, scan/blanking and reset.
module tb_display_scan_ctrl;

    logic       clk;
    logic       btn_reset;
    logic [7:0] val_in;
    logic       val_valid;
    logic       ready_a, busy_a, conv_a;
    logic [2:0] dig_a;
    logic [3:0] bcd_a;
    logic       ready_b, busy_b, conv_b;
    logic [2:0] dig_b;
    logic [3:0] bcd_b;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    display_scan_ctrl #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) u_dut (
        .clk(clk), .btn_reset(btn_reset), .val_in(val_in), .val_valid(val_valid),
        .val_ready(ready_a), .busy(busy_a), .conv_done(conv_a), .dig(dig_a), .bcd_out(bcd_a)
    );

    display_scan_ctrl #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) u_dut_nb (
        .clk(clk), .btn_reset(btn_reset), .val_in(val_in), .val_valid(val_valid),
        .val_ready(ready_b), .busy(busy_b), .conv_done(conv_b), .dig(dig_b), .bcd_out(bcd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_conv(input string tag);
        int unsigned lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!conv_a && lat < 20);
        check(tag, lat, 9);
    endtask

    task automatic load_value(input logic [7:0] v);
        int unsigned waited = 0;
        @(negedge clk);
        while (!ready_a && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("ready_before_load", ready_a, 1);
        val_in    = v;
        val_valid = 1'b1;
        @(posedge clk); #1;
        val_valid = 1'b0;
        wait_conv("latency");
    endtask

    // Unseen digits read back as E so a blanked slot is distinguishable from a shown value.
    task automatic scan_capture(input bit use_nb, output logic [11:0] digits,
                                output int unsigned n_u, output int unsigned n_t,
                                output int unsigned n_h, output bit bad);
        logic [3:0] h, t, u, b;
        logic [2:0] d;
        h = 4'hE; t = 4'hE; u = 4'hE;
        n_u = 0; n_t = 0; n_h = 0; bad = 1'b0;
        @(posedge clk);
        repeat (12) begin
            @(negedge clk);
            d = use_nb ? dig_b : dig_a;
            b = use_nb ? bcd_b : bcd_a;
            case (d)
                3'b110:  begin u = b; n_u++; end
                3'b101:  begin t = b; n_t++; end
                3'b011:  begin h = b; n_h++; end
                3'b111:  if (b != 4'hF) bad = 1'b1;
                default: bad = 1'b1;
            endcase
        end
        digits = {h, t, u};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] digits, exp_digits;
        int unsigned n_u, n_t, n_h, n_low;
        bit          bad, seen;

        btn_reset = 1'b1;
        val_in    = '0;
        val_valid = 1'b0;

        // 1. reset state and first scan output
        #22;
        check("rst_dig", dig_a, 3'b111);
        check("rst_bcd", bcd_a, 4'hF);
        check("rst_ready", ready_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_conv", conv_a, 0);
        @(negedge clk);
        btn_reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_dig", dig_a, 3'b110);
        check("post_rst_bcd", bcd_a, 4'h0);

        // 2. 255 with dwell counts
        load_value(8'd255);
        scan_capture(1'b0, digits, n_u, n_t, n_h, bad);
        check("disp_255", digits, 12'h255);
        check("dwell_uni", n_u, 4);
        check("dwell_ten", n_t, 4);
        check("dwell_hun", n_h, 4);
        check("blank_ok_255", bad, 0);

        // 3. leading-zero blanking vs interior zero
        load_value(8'd7);
        scan_capture(1'b0, digits, n_u, n_t, n_h, bad);
        check("disp_7", digits, 12'hEE7);
        check("dwell_uni_7", n_u, 4);
        check("blank_ok_7", bad, 0);
        load_value(8'd105);
        scan_capture(1'b0, digits, n_u, n_t, n_h, bad);
        check("disp_105", digits, 12'h105);

        // 4. val_valid held across two values
        @(negedge clk);
        val_in    = 8'd200;
        val_valid = 1'b1;
        @(posedge clk); #1;
        check("b2b_busy", busy_a, 1);
        check("b2b_ready", ready_a, 0);
        val_in = 8'd50;
        n_low  = 1;
        do begin
            @(posedge clk); #1;
            if (!ready_a) n_low++;
        end while (!ready_a && n_low < 30);
        check("b2b_ready_low_cycles", n_low, 9);
        check("b2b_conv_200", conv_a, 1);
        @(posedge clk); #1;
        val_valid = 1'b0;
        check("b2b_accept_50", busy_a, 1);
        wait_conv("latency_50");
        scan_capture(1'b0, digits, n_u, n_t, n_h, bad);
        check("disp_50", digits, 12'hE50);
        check("blank_ok_50", bad, 0);

        // 5. reset in the middle of a conversion
        @(negedge clk);
        val_in    = 8'd99;
        val_valid = 1'b1;
        @(posedge clk); #1;
        val_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        btn_reset = 1'b1;
        #1;
        check("mid_rst_dig", dig_a, 3'b111);
        check("mid_rst_bcd", bcd_a, 4'hF);
        check("mid_rst_ready", ready_a, 1);
        check("mid_rst_busy", busy_a, 0);
        repeat (2) @(negedge clk);
        btn_reset = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (conv_a) seen = 1'b1;
        end
        check("mid_rst_no_conv", seen, 0);
        scan_capture(1'b0, digits, n_u, n_t, n_h, bad);
        check("mid_rst_disp", digits, 12'hEE0);
        load_value(8'd42);
        scan_capture(1'b0, digits, n_u, n_t, n_h, bad);
        check("after_rst_42", digits, 12'hE42);

        // 6. full sweep on the non-blanking instance
        for (int v = 0; v < 256; v++) begin
            load_value(8'(v));
            scan_capture(1'b1, digits, n_u, n_t, n_h, bad);
            exp_digits = {4'(v / 100), 4'((v % 100) / 10), 4'(v % 10)};
            check("sweep", digits, exp_digits);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
